// File: rtl/isa_types.sv
// Shared ISA-level widths and the fetch-stage types used by instruction_fetch.
package isa_types;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [ILEN-1:0] bits;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, in-order instruction memory requests, a small instruction
// buffer towards decode, and redirect handling with stale-response dropping.

// Instruction buffer: circular FIFO of {bits, pc} with flush, head shown combinationally.
module fetch_fifo
   import isa_types::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush_i,
   input  logic                             push_i,
   input  fetch_entry_t                     data_i,
   input  logic                             pop_i,
   output fetch_entry_t                     head_o,
   output logic                             full_o,
   output logic                             empty_o,
   output logic [$clog2(DEPTH + 1)-1:0]     count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   // Pointer and occupancy update; flush returns the buffer to empty.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push_i && !pop_i)      count_d = count_q + CW'(1);
         else if (pop_i && !push_i) count_d = count_q - CW'(1);
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   // Upstream credit accounting must never let a write land on a full buffer.
   always_ff @(posedge clk) begin
      if (rst_n && push_i && !flush_i) assert (!full_o || pop_i);
   end

endmodule

// Fetch stage top: PC, request credit, redirect and drain control.
module instruction_fetch
   import isa_types::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr_bits,
   output logic [XLEN-1:0] instr_pc
);

   localparam int          CW      = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic [CW-1:0]   fifo_count;
   logic            fifo_full, fifo_empty;
   logic            push, pop, req_fire;
   logic [CW:0]     credit_used;
   logic [XLEN-1:0] resp_pc;
   fetch_entry_t    head, push_entry;
   logic            unused_fifo_full;
   logic            unused_redirect_lsb;

   assign unused_fifo_full    = fifo_full;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // An entry leaving the buffer this cycle frees its slot for a request this cycle.
   assign pop         = instr_valid && instr_ready;
   assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};

   assign imem_req_valid = rst_n && (state_q == FETCH) && !redirect_valid
                           && (credit_used < DEPTH_C);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Requests are sequential, so the oldest live request sits outst_q words behind pc_q.
   assign resp_pc    = pc_q - (XLEN'(outst_q) << 2);
   assign push       = imem_resp_valid && (drop_q == '0) && !redirect_valid;
   assign push_entry = '{bits: imem_resp_data, pc: resp_pc};

   assign instr_valid = !fifo_empty && !redirect_valid;
   assign instr_bits  = fifo_empty ? '0 : head.bits;
   assign instr_pc    = fifo_empty ? '0 : head.pc;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect_valid),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Next-state: redirect overrides issue; responses always retire one outstanding request.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      outst_d = outst_q;
      drop_d  = drop_q;
      if (imem_resp_valid) outst_d = outst_q - CW'(1);
      if (redirect_valid) begin
         pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
         drop_d  = outst_d;
         state_d = (outst_d != '0) ? DRAIN : FETCH;
      end else begin
         if (req_fire) begin
            pc_d    = pc_q + XLEN'(4);
            outst_d = outst_d + CW'(1);
         end
         if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
         if ((state_q == DRAIN) && (drop_d == '0)) state_d = FETCH;
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model with variable latency, scoreboard of
// expected {bits, pc} pushed on request acceptance, and a separate output monitor.
module tb_instruction_fetch;
   import isa_types::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_bits;
   logic [31:0] instr_pc;

   instruction_fetch #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr_bits      (instr_bits),
      .instr_pc        (instr_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [63:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          lat    = 1;
   logic [31:0] exp_req_pc;
   bit          prev_pend;
   logic [31:0] prev_addr;
   bit          last_req_valid;
   bit          last_instr_valid;
   logic [31:0] last_req_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"},   64'(imem_req_valid), 64'(0));
      check({tag, "_instr_valid"}, 64'(instr_valid),    64'(0));
      check({tag, "_req_addr"},    64'(imem_req_addr),  64'(RESET_PC));
      check({tag, "_instr_bits"},  64'(instr_bits),     64'(0));
      check({tag, "_instr_pc"},    64'(instr_pc),       64'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n           = 1'b0;
      imem_req_ready  = 1'b0;
      instr_ready     = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      mq.delete();
      exp_q.delete();
      exp_req_pc = RESET_PC;
      prev_pend  = 1'b0;
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock of stimulus: memory model, request-side checks, scoreboard pushes.
   task automatic cycle(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
      bit fire;
      @(negedge clk);
      cyc++;
      imem_resp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
      imem_resp_data  = imem_resp_valid ? mem_word(mq[0].addr) : $urandom;
      imem_req_ready  = rdy;
      instr_ready     = irdy;
      redirect_valid  = redir;
      redirect_pc     = rpc;
      #1;
      last_req_valid   = imem_req_valid;
      last_req_addr    = imem_req_addr;
      last_instr_valid = instr_valid;
      fire = imem_req_valid && rdy;
      if (redir) begin
         check("req_valid_in_redirect",   64'(imem_req_valid), 64'(0));
         check("instr_valid_in_redirect", 64'(instr_valid),    64'(0));
      end else if (prev_pend) begin
         check("req_hold_valid", 64'(imem_req_valid), 64'(1));
         check("req_hold_addr",  64'(imem_req_addr),  64'(prev_addr));
      end
      if (imem_req_valid) check("req_addr", 64'(imem_req_addr), 64'(exp_req_pc));
      if (fire) begin
         mq.push_back('{addr: imem_req_addr, due: cyc + lat});
         exp_q.push_back({mem_word(exp_req_pc), exp_req_pc});
         exp_req_pc = exp_req_pc + 32'd4;
         check("credit_limit",
               64'(exp_q.size() <= DEPTH + ((instr_valid && irdy) ? 1 : 0)), 64'(1));
      end
      if (imem_resp_valid) void'(mq.pop_front());
      if (redir) begin
         exp_q.delete();
         exp_req_pc = {rpc[31:2], 2'b00};
      end
      prev_pend = imem_req_valid && !rdy && !redir;
      prev_addr = imem_req_addr;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() > 0 || mq.size() > 0) && n < 100) begin
         cycle(1'b0, 1'b1, 1'b0, 32'h0);
         n++;
      end
      if (n >= 100) fail("drain_timeout", 64'(exp_q.size()), 64'(0));
   endtask

   // Output monitor: every accepted instruction is compared with the scoreboard head.
   always @(negedge clk) begin : monitor
      logic [63:0] e;
      #2;
      if (rst_n && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            fail("unexpected_instr_pc", 64'(instr_pc), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("instr_pc",   64'(instr_pc),   64'(e[31:0]));
            check("instr_bits", 64'(instr_bits), 64'(e[63:32]));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      rst_n           = 1'b0;
      imem_req_ready  = 1'b0;
      instr_ready     = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      exp_req_pc      = RESET_PC;

      // 1-cycle memory, decode always ready: back-to-back 0x0, 0x4, 0x8
      do_reset();
      lat = 1;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         check("b2b_valid", 64'(last_req_valid), 64'(1));
         check("b2b_addr",  64'(last_req_addr),  64'(4 * i));
      end
      drain();

      // decode stalled: requests stop once two words are buffered
      do_reset();
      lat = 1;
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("stall_req_valid",   64'(last_req_valid),   64'(0));
      check("stall_instr_valid", 64'(last_instr_valid), 64'(1));
      check("stall_buffered",    64'(exp_q.size()),     64'(2));
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("resume_valid", 64'(last_req_valid), 64'(1));
      check("resume_addr",  64'(last_req_addr),  64'(32'h8));
      drain();

      // 3-cycle memory, redirect to 0x100 with two requests in flight
      do_reset();
      lat = 3;
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b1, 32'h100);
      n = 0;
      do begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         n++;
         if (!last_req_valid) check("drain_instr_valid", 64'(last_instr_valid), 64'(0));
      end while (!last_req_valid && n < 10);
      check("redir_req_valid", 64'(last_req_valid), 64'(1));
      check("redir_req_addr",  64'(last_req_addr),  64'(32'h100));
      drain();

      // redirect to 0x203 while decode would accept a buffered word
      do_reset();
      lat = 1;
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("prepop_instr_valid", 64'(last_instr_valid), 64'(1));
      cycle(1'b1, 1'b1, 1'b1, 32'h203);
      check("redir_pop_instr_valid", 64'(last_instr_valid), 64'(0));
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("redir203_valid", 64'(last_req_valid), 64'(1));
      check("redir203_addr",  64'(last_req_addr),  64'(32'h200));
      drain();

      // PC wrap from 0xFFFF_FFFC to 0
      do_reset();
      lat = 1;
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("wrap_addr_hi", 64'(last_req_addr), 64'(32'hFFFF_FFFC));
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("wrap_valid",   64'(last_req_valid), 64'(1));
      check("wrap_addr_lo", 64'(last_req_addr),  64'(32'h0));
      drain();

      // asynchronous reset with one request outstanding
      lat = 3;
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("midrst_issue", 64'(last_req_valid), 64'(1));
      @(negedge clk);
      #3;
      rst_n           = 1'b0;
      imem_resp_valid = 1'b0;
      mq.delete();
      exp_q.delete();
      #1;
      check_reset_outputs("midrst");
      do_reset();
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("postrst_valid", 64'(last_req_valid), 64'(1));
      check("postrst_addr",  64'(last_req_addr),  64'(RESET_PC));
      drain();

      // randomized traffic: handshakes, latencies and redirects
      do_reset();
      for (int blk = 0; blk < 15; blk++) begin
         lat = $urandom_range(1, 4);
         for (int i = 0; i < 200; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0, $urandom);
         end
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
